// File: rtl/uart_transmitter.sv
// uart_transmitter: byte-wide UART transmitter.
// Frame is start(0), 8 data bits LSB first, even parity, one stop(1).
// Includes a per-frame baud tick generator selected from an 8-entry table,
// a frame FSM and a level-sampled write handshake. All outputs are registered.
module uart_transmitter #(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  // Baud rate for each baud_select code.
  function automatic int baud_of(input int sel);
    case (sel)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clock divider producing OVERSAMPLE ticks per bit.
  function automatic int calc_div(input int baud);
    longint den;
    den = longint'(OVERSAMPLE) * longint'(baud);
    return int'((longint'(CLK_HZ) + den / 2) / den);
  endfunction

  localparam int DIV_MAX = calc_div(baud_of(0));
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam int OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Divider constants, one per baud code, folded at elaboration.
  logic [DIV_W-1:0] div_table [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div
      assign div_table[gi] = DIV_W'(calc_div(baud_of(gi)));
    end
  endgenerate

  state_t           state_q, state_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;

  logic tick;
  logic bit_end;

  // Tick when the divider wraps; a bit ends on the last tick of OVERSAMPLE.
  always_comb begin
    tick    = (state_q != ST_IDLE) && (tick_cnt_q == div_q - DIV_W'(1));
    bit_end = tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  end

  // Next-state logic for the frame FSM, tick generator and datapath.
  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shift_d    = shift_q;
    parity_d   = parity_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
    if (tick) begin
      os_cnt_d = (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OS_W'(1);
    end else begin
      os_cnt_d = os_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        os_cnt_d   = '0;
        txd_d      = 1'b1;
        busy_d     = 1'b0;
        if (Tx_WR && Tx_EN) begin
          shift_d   = Tx_DATA;
          parity_d  = ^Tx_DATA;
          div_d     = div_table[baud_select];
          bit_cnt_d = '0;
          state_d   = ST_START;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
            txd_d   = parity_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      div_q      <= '0;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;
  assign Tx_DONE = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of the UART transmitter frame format,
// bit timing, handshake rules, back-to-back frames and mid-frame reset.
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       Tx_EN;
  logic [2:0] baud_select;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  int total;
  int bad;

  uart_transmitter #(
    .CLK_HZ    (50000000),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_EN      (Tx_EN),
    .baud_select(baud_select),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY),
    .Tx_DONE    (Tx_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle write request; called and returns on a falling edge.
  task automatic do_write(input logic [7:0] data, input logic [2:0] sel);
    Tx_DATA     = data;
    baud_select = sel;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask

  // Observer: waits for the start bit, then records mid-bit levels, glitches
  // off bit boundaries, BUSY drops and DONE pulses up to the expected DONE cycle.
  task automatic capture_frame(input int bit_clks, input int fall_limit,
                               output int waited, output logic [10:0] bits,
                               output int unstable, output int busy_bad,
                               output int done_cnt, output int done_at);
    logic prev;
    waited   = 0;
    bits     = 'x;
    unstable = 0;
    busy_bad = 0;
    done_cnt = 0;
    done_at  = -1;
    while (TxD !== 1'b0 && waited < fall_limit) begin
      @(negedge clk);
      waited++;
    end
    if (TxD !== 1'b0) begin
      waited = -1;
      return;
    end
    prev = 1'b0;
    for (int c = 0; c <= 11 * bit_clks; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 11 * bit_clks) begin
        if ((c % bit_clks) == bit_clks / 2) bits[c / bit_clks] = TxD;
        if ((c % bit_clks) != 0 && TxD !== prev) unstable++;
        if (Tx_BUSY !== 1'b1) busy_bad++;
      end
      if (Tx_DONE === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      prev = TxD;
    end
  endtask

  task automatic test_reset();
    int idle_bad;
    reset       = 1'b0;
    Tx_DATA     = 8'h00;
    Tx_WR       = 1'b0;
    Tx_EN       = 1'b0;
    baud_select = 3'b000;
    repeat (5) @(negedge clk);
    total++; if (TxD !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", TxD); end
    total++; if (Tx_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Tx_BUSY); end
    total++; if (Tx_DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Tx_DONE); end
    reset = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) idle_bad++;
    end
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL idle_quiet got=%0d bad cycles want=0", idle_bad); end
    $display("reset and 1000 idle cycles observed, off-idle cycles=%0d", idle_bad);
  endtask

  task automatic test_single_byte();
    int w, uns, bb, dc, da;
    logic [10:0] bits;
    do_write(8'hA5, 3'b111);
    capture_frame(432, 4, w, bits, uns, bb, dc, da);
    $display("frame data=0xa5 sel=111 bits=%b done_at=%0d", bits, da);
    total++; if (w !== 0) begin bad++; $display("FAIL a5_start_latency got=%0d want=0", w); end
    total++; if (bits !== 11'b10101001010) begin bad++; $display("FAIL a5_bits got=%b want=%b", bits, 11'b10101001010); end
    total++; if (uns !== 0) begin bad++; $display("FAIL a5_bit_width got=%0d glitches want=0", uns); end
    total++; if (bb !== 0) begin bad++; $display("FAIL a5_busy got=%0d low cycles want=0", bb); end
    total++; if (dc !== 1) begin bad++; $display("FAIL a5_done_count got=%0d want=1", dc); end
    total++; if (da !== 4752) begin bad++; $display("FAIL a5_done_time got=%0d want=4752", da); end
    total++; if (Tx_BUSY !== 1'b0) begin bad++; $display("FAIL a5_busy_at_done got=%b want=0", Tx_BUSY); end
  endtask

  task automatic test_parity_rate();
    int w, uns, bb, dc, da;
    logic [10:0] bits;
    do_write(8'h07, 3'b110);
    capture_frame(864, 4, w, bits, uns, bb, dc, da);
    $display("frame data=0x07 sel=110 bits=%b done_at=%0d", bits, da);
    total++; if (bits !== 11'b11000001110) begin bad++; $display("FAIL 07_bits got=%b want=%b", bits, 11'b11000001110); end
    total++; if (bits[9] !== 1'b1) begin bad++; $display("FAIL 07_parity got=%b want=1", bits[9]); end
    total++; if (uns !== 0) begin bad++; $display("FAIL 07_bit_width got=%0d glitches want=0", uns); end
    total++; if (da !== 9504) begin bad++; $display("FAIL 07_done_time got=%0d want=9504", da); end
    total++; if (dc !== 1) begin bad++; $display("FAIL 07_done_count got=%0d want=1", dc); end
  endtask

  task automatic test_write_ignored();
    int w, uns, bb, dc, da, extra, dis_bad;
    logic [10:0] bits;
    do_write(8'h0F, 3'b111);
    fork
      capture_frame(432, 4, w, bits, uns, bb, dc, da);
      begin
        repeat (1000) @(negedge clk);
        Tx_DATA = 8'hFF;
        Tx_WR   = 1'b1;
        repeat (3) @(negedge clk);
        Tx_WR = 1'b0;
      end
    join
    $display("frame data=0x0f sel=111 with busy write bits=%b done_at=%0d", bits, da);
    total++; if (bits !== 11'b10000011110) begin bad++; $display("FAIL busy_wr_bits got=%b want=%b", bits, 11'b10000011110); end
    total++; if (dc !== 1) begin bad++; $display("FAIL busy_wr_done_count got=%0d want=1", dc); end
    total++; if (da !== 4752) begin bad++; $display("FAIL busy_wr_done_time got=%0d want=4752", da); end
    extra = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_DONE !== 1'b0 || Tx_BUSY !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_wr_no_queue got=%0d active cycles want=0", extra); end
    Tx_EN   = 1'b0;
    Tx_DATA = 8'h00;
    Tx_WR   = 1'b1;
    dis_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) dis_bad++;
    end
    Tx_WR = 1'b0;
    Tx_EN = 1'b1;
    $display("write with enable low held 1000 cycles, active cycles=%0d", dis_bad);
    total++; if (dis_bad !== 0) begin bad++; $display("FAIL disabled_wr got=%0d active cycles want=0", dis_bad); end
  endtask

  task automatic test_back_to_back();
    int w1, uns1, bb1, dc1, da1;
    int w2, uns2, bb2, dc2, da2;
    logic [10:0] b1, b2;
    Tx_DATA     = 8'h55;
    baud_select = 3'b111;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_DATA = 8'h3C;
    capture_frame(432, 2, w1, b1, uns1, bb1, dc1, da1);
    fork
      capture_frame(432, 4, w2, b2, uns2, bb2, dc2, da2);
      begin
        @(negedge clk);
        Tx_WR       = 1'b0;
        baud_select = 3'b000;
      end
    join
    $display("frame data=0x55 sel=111 bits=%b done_at=%0d", b1, da1);
    $display("frame data=0x3c sel=111 bits=%b gap=%0d done_at=%0d", b2, w2, da2);
    total++; if (b1 !== 11'b10010101010) begin bad++; $display("FAIL b2b_first_bits got=%b want=%b", b1, 11'b10010101010); end
    total++; if (da1 !== 4752) begin bad++; $display("FAIL b2b_first_done got=%0d want=4752", da1); end
    total++; if (w2 !== 1) begin bad++; $display("FAIL b2b_gap got=%0d want=1", w2); end
    total++; if (b2 !== 11'b10001111000) begin bad++; $display("FAIL b2b_second_bits got=%b want=%b", b2, 11'b10001111000); end
    total++; if (uns2 !== 0) begin bad++; $display("FAIL b2b_second_width got=%0d glitches want=0", uns2); end
    total++; if (da2 !== 4752) begin bad++; $display("FAIL b2b_second_done got=%0d want=4752", da2); end
    total++; if ((^b1[9:1]) !== 1'b0 || (^b2[9:1]) !== 1'b0) begin bad++; $display("FAIL b2b_parity_err got=%b%b want=00", ^b1[9:1], ^b2[9:1]); end
    total++; if (b1[10] !== 1'b1 || b2[10] !== 1'b1) begin bad++; $display("FAIL b2b_frame_err got=%b%b want=11", b1[10], b2[10]); end
    baud_select = 3'b111;
  endtask

  task automatic test_reset_mid_frame();
    int w, uns, bb, dc, da, post_bad;
    logic [10:0] bits;
    do_write(8'h00, 3'b111);
    repeat (4 * 432 + 200) @(negedge clk);
    total++; if (TxD !== 1'b0) begin bad++; $display("FAIL rst_pre_txd got=%b want=0", TxD); end
    reset = 1'b0;
    #1;
    total++; if (TxD !== 1'b1) begin bad++; $display("FAIL rst_async_txd got=%b want=1", TxD); end
    total++; if (Tx_BUSY !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", Tx_BUSY); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    post_bad = 0;
    for (int i = 0; i < 3500; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_DONE !== 1'b0 || Tx_BUSY !== 1'b0) post_bad++;
    end
    $display("reset during data bit 3, post-reset active cycles=%0d", post_bad);
    total++; if (post_bad !== 0) begin bad++; $display("FAIL rst_no_done got=%0d active cycles want=0", post_bad); end
    do_write(8'h81, 3'b111);
    capture_frame(432, 4, w, bits, uns, bb, dc, da);
    $display("frame data=0x81 sel=111 bits=%b done_at=%0d", bits, da);
    total++; if (bits !== 11'b10100000010) begin bad++; $display("FAIL rst_after_bits got=%b want=%b", bits, 11'b10100000010); end
    total++; if (da !== 4752) begin bad++; $display("FAIL rst_after_done got=%0d want=4752", da); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_byte();
    test_parity_rate();
    test_write_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
